// File: rtl/csr_access_arbiter_pkg.sv
// Shared types and constants for the CSR access arbiter: bus widths,
// the forced-completion read pattern and the FSM state encoding.
package csr_access_arbiter_pkg;

  localparam int AXIL_DATA_WIDTH = 32;
  localparam int AXIL_STRB_WIDTH = 4;

  // Read data returned to a requester whose access was force-completed.
  localparam logic [AXIL_DATA_WIDTH-1:0] CSR_TMO_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } csr_state_e;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting index at or after ptr,
// wrapping modulo N. Produces a one-hot grant, its index and an any flag.
module rr_arbiter
  import csr_access_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    int i;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    i   = 0;
    for (int off = N - 1; off >= 0; off--) begin
      i = (int'(ptr) + off) % N;
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IW'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csr_access_arbiter.sv
// Round-robin arbiter serializing several requesters onto one CSR
// write/read port, with a per-access timeout that forces completion.
module csr_access_arbiter
  import csr_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int IW = idx_w(NUM_REQ),
  localparam int DW = AXIL_DATA_WIDTH,
  localparam int SW = AXIL_STRB_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ*AXIL_ADDR_WIDTH-1:0] req_waddr,
  input  logic [NUM_REQ*DW-1:0]              req_wdata,
  input  logic [NUM_REQ*SW-1:0]              req_wstrb,
  input  logic [NUM_REQ-1:0]                 req_wvalid,
  output logic [NUM_REQ-1:0]                 req_wready,
  input  logic [NUM_REQ*AXIL_ADDR_WIDTH-1:0] req_raddr,
  input  logic [NUM_REQ-1:0]                 req_rvalid,
  output logic [DW-1:0]                      req_rdata,
  output logic [NUM_REQ-1:0]                 req_rready,
  output logic [AXIL_ADDR_WIDTH-1:0]         waddr,
  output logic [DW-1:0]                      wdata,
  output logic [SW-1:0]                      wstrb,
  output logic                               wvalid,
  input  logic                               wready,
  output logic [AXIL_ADDR_WIDTH-1:0]         raddr,
  output logic                               rvalid,
  input  logic [DW-1:0]                      rdata,
  input  logic                               rready,
  output logic [IW-1:0]                      grant_id,
  output logic                               busy,
  output logic                               timeout_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [NUM_REQ-1:0][AXIL_ADDR_WIDTH-1:0] waddr_a, raddr_a;
  logic [NUM_REQ-1:0][DW-1:0]              wdata_a;
  logic [NUM_REQ-1:0][SW-1:0]              wstrb_a;

  assign waddr_a = req_waddr;
  assign raddr_a = req_raddr;
  assign wdata_a = req_wdata;
  assign wstrb_a = req_wstrb;

  csr_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q;
  logic [TW-1:0] tmo_cnt_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req (req_wvalid | req_rvalid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  logic at_limit;
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      assign at_limit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_tmo
      assign at_limit = 1'b0;
    end
  endgenerate

  // Handshakes use the raw valids so the timeout can gate the outputs
  // without forming a combinational loop; a handshake beats the timeout.
  logic gid_wv, hs_w, hs_r, tmo;
  assign gid_wv = req_wvalid[grant_id];
  assign hs_w   = (state_q == ST_WRITE) & gid_wv & wready;
  assign hs_r   = (state_q == ST_READ) & rready;
  assign tmo    = (state_q != ST_IDLE) & at_limit & ~(hs_w | hs_r);

  assign busy  = (state_q != ST_IDLE);
  assign waddr = waddr_a[grant_id];
  assign wdata = wdata_a[grant_id];
  assign wstrb = wstrb_a[grant_id];
  assign raddr = raddr_a[grant_id];

  always_comb begin
    state_d     = state_q;
    wvalid      = 1'b0;
    rvalid      = 1'b0;
    req_wready  = '0;
    req_rready  = '0;
    req_rdata   = '0;
    timeout_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) state_d = req_wvalid[arb_idx] ? ST_WRITE : ST_READ;
      end
      ST_WRITE: begin
        wvalid               = gid_wv & ~tmo;
        req_wready[grant_id] = wready | tmo;
        timeout_err          = tmo;
        if (hs_w | tmo) state_d = ST_IDLE;
      end
      ST_READ: begin
        rvalid               = ~tmo;
        req_rready[grant_id] = rready | tmo;
        req_rdata            = tmo ? CSR_TMO_DATA : rdata;
        timeout_err          = tmo;
        if (hs_r | tmo) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_id  <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && arb_any) begin
        grant_id <= arb_idx;
        rr_ptr_q <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end
      // Held at zero in IDLE, so every new access starts from a clean count.
      if (state_q == ST_IDLE) tmo_cnt_q <= '0;
      else                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter: write, contention, priority,
// timeout, handshake-at-timeout boundary and mid-transaction reset.
module tb_csr_access_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] req_waddr, req_raddr;
  logic [N*32-1:0] req_wdata;
  logic [N*4-1:0]  req_wstrb;
  logic [N-1:0]    req_wvalid, req_rvalid;
  logic [N-1:0]    req_wready, req_rready;
  logic [31:0]     req_rdata;
  logic [AW-1:0]   waddr, raddr;
  logic [31:0]     wdata, rdata;
  logic [3:0]      wstrb;
  logic            wvalid, wready, rvalid, rready;
  logic [0:0]      grant_id;
  logic            busy, timeout_err;

  int checks   = 0;
  int failures = 0;

  csr_access_arbiter #(.NUM_REQ(N), .AXIL_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_waddr(req_waddr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_wvalid(req_wvalid), .req_wready(req_wready),
    .req_raddr(req_raddr), .req_rvalid(req_rvalid),
    .req_rdata(req_rdata), .req_rready(req_rready),
    .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .raddr(raddr), .rvalid(rvalid), .rdata(rdata), .rready(rready),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_waddr = '0; req_raddr = '0; req_wdata = '0; req_wstrb = '0;
    req_wvalid = '0; req_rvalid = '0;
    wready = 1'b0; rready = 1'b0; rdata = '0;
    #2;
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_grant",     32'(grant_id), 32'd0);
    check("rst_wvalid",    32'(wvalid), 32'd0);
    check("rst_rvalid",    32'(rvalid), 32'd0);
    check("rst_req_wrdy",  32'(req_wready), 32'd0);
    check("rst_req_rrdy",  32'(req_rready), 32'd0);
    check("rst_req_rdata", req_rdata, 32'd0);
    check("rst_tmo_err",   32'(timeout_err), 32'd0);
    tick;
    rst = 1'b0;

    // single write, target ready immediately
    req_waddr[31:0] = 32'h10; req_wdata[31:0] = 32'hA5A5_0001; req_wstrb[3:0] = 4'hF;
    req_wvalid = 2'b01; wready = 1'b1;
    #1;
    check("w1_idle_wvalid", 32'(wvalid), 32'd0);
    tick;
    check("w1_wvalid", 32'(wvalid), 32'd1);
    check("w1_waddr",  waddr, 32'h10);
    check("w1_wdata",  wdata, 32'hA5A5_0001);
    check("w1_wstrb",  32'(wstrb), 32'hF);
    check("w1_wrdy",   32'(req_wready), 32'b01);
    check("w1_busy",   32'(busy), 32'd1);
    tick;
    req_wvalid = '0;
    #1;
    check("w1_busy_fall", 32'(busy), 32'd0);
    check("w1_wrdy_fall", 32'(req_wready), 32'd0);

    // contention from a fresh pointer
    rst = 1'b1; #1; rst = 1'b0;
    req_waddr[63:32] = 32'h14;
    req_wvalid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("cont_grant", 32'(grant_id), 32'(k % 2));
      check("cont_wrdy",  32'(req_wready), (k % 2 == 1) ? 32'b10 : 32'b01);
      tick;
      check("cont_gap",   32'(busy), 32'd0);
    end
    req_wvalid = '0;

    // write beats read within one requester
    req_waddr[63:32] = 32'h20; req_raddr[63:32] = 32'h24;
    req_wvalid = 2'b10; req_rvalid = 2'b10;
    rdata = 32'h1234_5678; rready = 1'b0; wready = 1'b1;
    tick;
    check("pri_grant",  32'(grant_id), 32'd1);
    check("pri_wvalid", 32'(wvalid), 32'd1);
    check("pri_waddr",  waddr, 32'h20);
    check("pri_wrdy",   32'(req_wready), 32'b10);
    check("pri_rvalid_lo", 32'(rvalid), 32'd0);
    tick;
    req_wvalid = '0; rready = 1'b1;
    #1;
    check("pri_gap", 32'(busy), 32'd0);
    tick;
    check("pri_rvalid", 32'(rvalid), 32'd1);
    check("pri_raddr",  raddr, 32'h24);
    check("pri_rrdy",   32'(req_rready), 32'b10);
    check("pri_rdata",  req_rdata, 32'h1234_5678);
    tick;
    req_rvalid = '0; rready = 1'b0;
    #1;
    check("pri_rrdy_idle",  32'(req_rready), 32'd0);
    check("pri_rdata_idle", req_rdata, 32'd0);

    // unresponsive read target
    req_raddr[31:0] = 32'h40; req_rvalid = 2'b01; rdata = 32'h5555_AAAA;
    tick;
    check("tmo_rvalid", 32'(rvalid), 32'd1);
    repeat (14) tick;
    check("tmo_c15_err",  32'(timeout_err), 32'd0);
    check("tmo_c15_rrdy", 32'(req_rready), 32'd0);
    tick;
    check("tmo_err",    32'(timeout_err), 32'd1);
    check("tmo_rrdy",   32'(req_rready), 32'b01);
    check("tmo_rdata",  req_rdata, 32'hDEAD_BEEF);
    check("tmo_rvalid_drop", 32'(rvalid), 32'd0);
    tick;
    req_rvalid = '0;
    #1;
    check("tmo_err_pulse", 32'(timeout_err), 32'd0);
    check("tmo_idle",      32'(busy), 32'd0);
    req_raddr[63:32] = 32'h44; req_rvalid = 2'b10; rdata = 32'h0BAD_F00D; rready = 1'b1;
    tick;
    check("post_grant", 32'(grant_id), 32'd1);
    check("post_rrdy",  32'(req_rready), 32'b10);
    check("post_rdata", req_rdata, 32'h0BAD_F00D);
    check("post_err",   32'(timeout_err), 32'd0);
    tick;
    req_rvalid = '0; rready = 1'b0;
    #1;
    check("post_idle", 32'(busy), 32'd0);

    // handshake in the timeout cycle
    req_rvalid = 2'b01; rdata = 32'hCAFE_0001;
    tick;
    repeat (14) tick;
    check("bnd_c15_rrdy", 32'(req_rready), 32'd0);
    tick;
    rready = 1'b1;
    #1;
    check("bnd_rdata",  req_rdata, 32'hCAFE_0001);
    check("bnd_rrdy",   32'(req_rready), 32'b01);
    check("bnd_err",    32'(timeout_err), 32'd0);
    check("bnd_rvalid", 32'(rvalid), 32'd1);
    tick;
    req_rvalid = '0; rready = 1'b0;
    #1;
    check("bnd_idle", 32'(busy), 32'd0);

    // reset in the middle of a write
    req_waddr[63:32] = 32'h30; req_wvalid = 2'b10; wready = 1'b0;
    tick;
    check("mrst_grant_pre",  32'(grant_id), 32'd1);
    check("mrst_wvalid_pre", 32'(wvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mrst_wvalid", 32'(wvalid), 32'd0);
    check("mrst_grant",  32'(grant_id), 32'd0);
    check("mrst_busy",   32'(busy), 32'd0);
    #1 rst = 1'b0;
    tick;
    check("mrst_regrant", 32'(grant_id), 32'd1);
    check("mrst_rewv",    32'(wvalid), 32'd1);
    check("mrst_waddr",   waddr, 32'h30);
    wready = 1'b1;
    #1;
    check("mrst_wrdy", 32'(req_wready), 32'b10);
    tick;
    req_wvalid = '0;
    #1;
    check("mrst_done", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
